rambus_stream_reader: RTL and testbench



---
 rtl/rambus_stream_reader.sv | 191 +++++++++++++++++++
 tb/tb_rambus_stream_reader.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rambus_stream_reader.sv
// rambus_stream_reader
// Wishbone initiator on the user-project side of the rambus. It reads a
// circular word range out of port B of the shared 1 kB OpenRAM, buffers
// the words in a small FIFO and hands them to a sample consumer over a
// valid/ready handshake.
//
// Parameters
//   DEPTH    FIFO depth in words (power of 2, >= 2)
//   TIMEOUT  cycles a bus cycle may wait for ack before it is abandoned (>= 1)
//
// Ports
//   wb_clk_i, wb_rst_ni        clock, asynchronous active-low reset
//   enable                     run streaming; low flushes FIFO and rearms address
//   start_addr, end_addr       inclusive circular word range
//   rambus_wb_*                Wishbone initiator towards the RAM wrapper
//   sample_o/_valid_o/_ready_i FIFO head word and handshake
//   fifo_level_o               FIFO occupancy
//   wrap_o                     one-cycle pulse after end_addr was fetched
//   timeout_o                  sticky bus-timeout flag
module rambus_stream_reader #(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 255
) (
   input  logic                       wb_clk_i,
   input  logic                       wb_rst_ni,
   input  logic                       enable,
   input  logic [7:0]                 start_addr,
   input  logic [7:0]                 end_addr,
   output logic                       rambus_wb_clk_o,
   output logic                       rambus_wb_rst_o,
   output logic                       rambus_wb_cyc_o,
   output logic                       rambus_wb_stb_o,
   output logic                       rambus_wb_we_o,
   output logic [3:0]                 rambus_wb_sel_o,
   output logic [31:0]                rambus_wb_dat_o,
   output logic [9:0]                 rambus_wb_adr_o,
   input  logic                       rambus_wb_ack_i,
   input  logic [31:0]                rambus_wb_dat_i,
   output logic [31:0]                sample_o,
   output logic                       sample_valid_o,
   input  logic                       sample_ready_i,
   output logic [$clog2(DEPTH):0]     fifo_level_o,
   output logic                       wrap_o,
   output logic                       timeout_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;
   localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      GAP   = 2'd2
   } state_t;

   state_t          state;
   state_t          next_state;

   logic [7:0]      word_addr;
   logic [TW-1:0]   to_count;
   logic            cyc_q;
   logic            wrap_q;
   logic            timeout_q;

   logic [31:0]     mem [DEPTH];
   logic [PW-1:0]   rd_ptr;
   logic [PW-1:0]   wr_ptr;
   logic [LW-1:0]   level;

   logic            got_ack;
   logic            expire;
   logic            launch;
   logic            flush;
   logic            push;
   logic            pop;
   logic            cyc_d;

   // Event decode shared by the FSM and the datapath. A fetch is only
   // launched while there is room, so a push can never overflow.
   assign got_ack = (state == FETCH) && rambus_wb_ack_i;
   assign expire  = (state == FETCH) && !rambus_wb_ack_i &&
                    (to_count == TW'(TIMEOUT - 1));
   assign launch  = (state == IDLE) && enable && !timeout_q &&
                    (level < LW'(DEPTH));
   assign flush   = (state == IDLE) && !enable;

   // State register.
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic: IDLE -> FETCH -> GAP -> IDLE.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (launch) next_state = FETCH;
         FETCH:   if (got_ack || expire) next_state = GAP;
         GAP:     next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Output decode: cyc is registered from the next state so it rises on
   // the launch edge and falls on the ack/timeout edge.
   always_comb begin
      cyc_d = (next_state == FETCH);
      push  = got_ack;
      pop   = (level != '0) && sample_ready_i;
   end

   // Bus strobe, address sequencing, wrap pulse and timeout handling.
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         cyc_q     <= 1'b0;
         word_addr <= 8'd0;
         to_count  <= '0;
         wrap_q    <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         cyc_q  <= cyc_d;
         wrap_q <= push && (word_addr == end_addr);
         if (launch) begin
            to_count <= '0;
         end else if ((state == FETCH) && !rambus_wb_ack_i) begin
            to_count <= to_count + 1'b1;
         end
         if (flush) begin
            word_addr <= start_addr;
         end else if (push) begin
            word_addr <= (word_addr == end_addr) ? start_addr : word_addr + 8'd1;
         end
         if (flush) begin
            timeout_q <= 1'b0;
         end else if (expire) begin
            timeout_q <= 1'b1;
         end
      end
   end

   // FIFO storage; reset to zero so the head reads 0 out of reset.
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (push && !flush) begin
         mem[wr_ptr] <= rambus_wb_dat_i;
      end
   end

   // FIFO pointers and occupancy; flush takes priority over everything.
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         level  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

   assign rambus_wb_clk_o = wb_clk_i;
   assign rambus_wb_rst_o = ~wb_rst_ni;
   assign rambus_wb_cyc_o = cyc_q;
   assign rambus_wb_stb_o = cyc_q;
   assign rambus_wb_we_o  = 1'b0;
   assign rambus_wb_sel_o = 4'hF;
   assign rambus_wb_dat_o = 32'd0;
   assign rambus_wb_adr_o = {word_addr, 2'b00};
   assign sample_o        = mem[rd_ptr];
   assign sample_valid_o  = (level != '0);
   assign fifo_level_o    = level;
   assign wrap_o          = wrap_q;
   assign timeout_o       = timeout_q;

endmodule

// File: tb/tb_rambus_stream_reader.sv
// Self-checking bench for rambus_stream_reader (DEPTH=4, TIMEOUT=8).
// A RAM responder model acks bus cycles after a programmable delay and
// pushes the word the reader ought to receive onto a scoreboard queue; a
// consumer monitor pops and compares whenever a sample is accepted.
module tb_rambus_stream_reader;

   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable;
   logic [7:0]  start_addr;
   logic [7:0]  end_addr;
   logic        wb_clk_o;
   logic        wb_rst_o;
   logic        cyc;
   logic        stb;
   logic        we;
   logic [3:0]  sel;
   logic [31:0] dat_o;
   logic [9:0]  adr;
   logic        ack;
   logic [31:0] dat_i;
   logic [31:0] sample;
   logic        valid;
   logic        ready;
   logic [2:0]  level;
   logic        wrap;
   logic        tmo;

   int passed = 0;
   int total  = 0;

   logic [31:0] ram [256];
   logic [31:0] exp_q[$];
   logic [31:0] pop_log[$];
   logic [9:0]  adr_log[$];
   logic [7:0]  exp_addr;
   int          ack_delay = 1;
   bit          ack_en = 1'b1;
   bit          rate_check = 1'b0;
   int          n_reads = 0;
   int          n_acks = 0;
   int          n_pops = 0;
   int          exp_wraps = 0;
   int          obs_wraps = 0;
   int          tick = 0;
   int          last_start = -1;

   always #5 clk = ~clk;

   rambus_stream_reader #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .wb_clk_i        (clk),
      .wb_rst_ni       (rst_n),
      .enable          (enable),
      .start_addr      (start_addr),
      .end_addr        (end_addr),
      .rambus_wb_clk_o (wb_clk_o),
      .rambus_wb_rst_o (wb_rst_o),
      .rambus_wb_cyc_o (cyc),
      .rambus_wb_stb_o (stb),
      .rambus_wb_we_o  (we),
      .rambus_wb_sel_o (sel),
      .rambus_wb_dat_o (dat_o),
      .rambus_wb_adr_o (adr),
      .rambus_wb_ack_i (ack),
      .rambus_wb_dat_i (dat_i),
      .sample_o        (sample),
      .sample_valid_o  (valid),
      .sample_ready_i  (ready),
      .fifo_level_o    (level),
      .wrap_o          (wrap),
      .timeout_o       (tmo)
   );

   // RAM responder: acks ack_delay ticks after a cycle starts, checks the
   // address against the bench's own range model and the mandatory gap.
   initial begin
      int  cnt;
      bit  in_cycle;
      bit  post_ack;
      cnt = 0;
      in_cycle = 1'b0;
      post_ack = 1'b0;
      ack = 1'b0;
      dat_i = '0;
      forever begin
         @(posedge clk);
         #1;
         tick++;
         if (ack) begin
            ack = 1'b0;
            cnt = 0;
            in_cycle = 1'b0;
            post_ack = 1'b1;
            total++;
            if (cyc !== 1'b0) $display("[TB] FAIL cyc_after_ack: cyc=%b required 0", cyc);
            else passed++;
         end else if (post_ack) begin
            post_ack = 1'b0;
            total++;
            if (cyc !== 1'b0) $display("[TB] FAIL gap_cycle: cyc=%b required 0", cyc);
            else passed++;
         end else if (cyc) begin
            if (!in_cycle) begin
               in_cycle = 1'b1;
               cnt = 0;
               n_reads++;
               adr_log.push_back(adr);
               total++;
               if (adr !== {exp_addr, 2'b00})
                  $display("[TB] FAIL bus_addr: adr=%h required %h", adr, {exp_addr, 2'b00});
               else passed++;
               if (rate_check && last_start >= 0) begin
                  total++;
                  if (tick - last_start !== ack_delay + 3)
                     $display("[TB] FAIL throughput: interval=%0d required %0d", tick - last_start, ack_delay + 3);
                  else passed++;
               end
               last_start = tick;
            end
            if (ack_en && cnt == ack_delay) begin
               ack = 1'b1;
               dat_i = ram[adr[9:2]];
               exp_q.push_back(ram[exp_addr]);
               n_acks++;
               if (exp_addr == end_addr) begin
                  exp_addr = start_addr;
                  exp_wraps++;
               end else begin
                  exp_addr = exp_addr + 8'd1;
               end
            end else begin
               cnt++;
            end
         end else begin
            in_cycle = 1'b0;
            cnt = 0;
         end
      end
   end

   // Consumer monitor: scoreboard pop on every accepted sample.
   always @(negedge clk) begin
      if (valid && ready) begin
         n_pops++;
         pop_log.push_back(sample);
         total++;
         if (exp_q.size() == 0) begin
            $display("[TB] FAIL sample_unexpected: got %h required none", sample);
         end else begin
            logic [31:0] e;
            e = exp_q.pop_front();
            if (sample !== e) $display("[TB] FAIL sample_data: got %h required %h", sample, e);
            else passed++;
         end
      end
      if (wrap) obs_wraps++;
      total++;
      if (stb !== cyc) $display("[TB] FAIL stb_eq_cyc: stb=%b required %b", stb, cyc);
      else passed++;
   end

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Program a range and hold enable low long enough to rearm and flush.
   task automatic applyStimulus(input logic [7:0] s, input logic [7:0] e);
      start_addr = s;
      end_addr = e;
      enable = 1'b0;
      cycles(12);
      exp_q.delete();
      exp_addr = s;
   endtask

   task automatic wait_cyc_high(input string name);
      int k;
      k = 0;
      while (!cyc && k < 100) begin
         cycles(1);
         k++;
      end
      total++;
      if (!cyc) $display("[TB] FAIL %s_wait_cyc: cyc=%b required 1", name, cyc);
      else passed++;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      enable = 1'b0;
      ready = 1'b0;
      start_addr = 8'd0;
      end_addr = 8'd0;
      #23;
      total++; if (cyc !== 1'b0)      $display("[TB] FAIL reset_cyc: %b required 0", cyc); else passed++;
      total++; if (we !== 1'b0)       $display("[TB] FAIL reset_we: %b required 0", we); else passed++;
      total++; if (adr !== 10'd0)     $display("[TB] FAIL reset_adr: %h required 0", adr); else passed++;
      total++; if (valid !== 1'b0)    $display("[TB] FAIL reset_valid: %b required 0", valid); else passed++;
      total++; if (level !== 3'd0)    $display("[TB] FAIL reset_level: %0d required 0", level); else passed++;
      total++; if (sample !== 32'd0)  $display("[TB] FAIL reset_sample: %h required 0", sample); else passed++;
      total++; if (wrap !== 1'b0)     $display("[TB] FAIL reset_wrap: %b required 0", wrap); else passed++;
      total++; if (tmo !== 1'b0)      $display("[TB] FAIL reset_timeout: %b required 0", tmo); else passed++;
      total++; if (wb_rst_o !== 1'b1) $display("[TB] FAIL reset_rst_o: %b required 1", wb_rst_o); else passed++;
      total++; if (sel !== 4'hF)      $display("[TB] FAIL sel_const: %h required F", sel); else passed++;
      total++; if (dat_o !== 32'd0)   $display("[TB] FAIL dat_o_const: %h required 0", dat_o); else passed++;
      total++; if (wb_clk_o !== clk)  $display("[TB] FAIL clk_passthru: %b required %b", wb_clk_o, clk); else passed++;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      total++; if (wb_rst_o !== 1'b0) $display("[TB] FAIL run_rst_o: %b required 0", wb_rst_o); else passed++;
   endtask

   task automatic test_sequential();
      logic [31:0] want [5];
      int k;
      want = '{32'hA2, 32'hA3, 32'hA4, 32'hA5, 32'hA2};
      ack_delay = 1;
      ready = 1'b1;
      applyStimulus(8'd2, 8'd5);
      pop_log.delete();
      n_acks = 0;
      exp_wraps = 0;
      obs_wraps = 0;
      last_start = -1;
      rate_check = 1'b1;
      enable = 1'b1;
      k = 0;
      while (n_pops < 9 && k < 300) begin
         cycles(1);
         k++;
      end
      rate_check = 1'b0;
      enable = 1'b0;
      cycles(12);
      total++;
      if (pop_log.size() < 5) $display("[TB] FAIL seq_count: got %0d required >=5", pop_log.size());
      else passed++;
      for (int i = 0; i < 5 && i < pop_log.size(); i++) begin
         total++;
         if (pop_log[i] !== want[i]) $display("[TB] FAIL seq_word%0d: got %h required %h", i, pop_log[i], want[i]);
         else passed++;
      end
      total++;
      if (obs_wraps !== exp_wraps) $display("[TB] FAIL seq_wraps: got %0d required %0d", obs_wraps, exp_wraps);
      else passed++;
      total++;
      if (exp_wraps !== n_acks / 4) $display("[TB] FAIL seq_wrap_rate: got %0d required %0d", exp_wraps, n_acks / 4);
      else passed++;
      total++;
      if (level !== 3'd0) $display("[TB] FAIL seq_flush: level=%0d required 0", level);
      else passed++;
   endtask

   task automatic test_backpressure();
      int base;
      ack_delay = 1;
      ready = 1'b0;
      applyStimulus(8'd2, 8'd5);
      base = n_reads;
      enable = 1'b1;
      cycles(60);
      total++; if (n_reads - base !== 4) $display("[TB] FAIL bp_reads: got %0d required 4", n_reads - base); else passed++;
      total++; if (level !== 3'd4)       $display("[TB] FAIL bp_level_full: got %0d required 4", level); else passed++;
      total++; if (cyc !== 1'b0)         $display("[TB] FAIL bp_no_cyc: cyc=%b required 0", cyc); else passed++;
      ready = 1'b1;
      cycles(1);
      ready = 1'b0;
      total++; if (level !== 3'd3)       $display("[TB] FAIL bp_level_pop: got %0d required 3", level); else passed++;
      cycles(30);
      total++; if (n_reads - base !== 5) $display("[TB] FAIL bp_one_more: got %0d required 5", n_reads - base); else passed++;
      total++; if (level !== 3'd4)       $display("[TB] FAIL bp_refill: got %0d required 4", level); else passed++;
      enable = 1'b0;
      cycles(4);
      total++; if (valid !== 1'b0)       $display("[TB] FAIL bp_flush: valid=%b required 0", valid); else passed++;
   endtask

   task automatic test_inverted();
      logic [9:0] want [5];
      int k;
      want = '{10'h3F8, 10'h3FC, 10'h000, 10'h004, 10'h3F8};
      ack_delay = 0;
      ready = 1'b1;
      applyStimulus(8'd254, 8'd1);
      adr_log.delete();
      enable = 1'b1;
      k = 0;
      while (adr_log.size() < 5 && k < 200) begin
         cycles(1);
         k++;
      end
      enable = 1'b0;
      cycles(12);
      total++;
      if (adr_log.size() < 5) $display("[TB] FAIL inv_count: got %0d required >=5", adr_log.size());
      else passed++;
      for (int i = 0; i < 5 && i < adr_log.size(); i++) begin
         total++;
         if (adr_log[i] !== want[i]) $display("[TB] FAIL inv_adr%0d: got %h required %h", i, adr_log[i], want[i]);
         else passed++;
      end
   endtask

   task automatic test_timeout();
      int n;
      int base;
      ack_en = 1'b0;
      ready = 1'b1;
      applyStimulus(8'd3, 8'd6);
      enable = 1'b1;
      wait_cyc_high("to");
      n = 0;
      while (cyc && n < 50) begin
         cycles(1);
         n++;
      end
      total++; if (n !== TIMEOUT)    $display("[TB] FAIL to_cycles: got %0d required %0d", n, TIMEOUT); else passed++;
      total++; if (tmo !== 1'b1)     $display("[TB] FAIL to_flag: got %b required 1", tmo); else passed++;
      total++; if (level !== 3'd0)   $display("[TB] FAIL to_no_push: level=%0d required 0", level); else passed++;
      base = n_reads;
      cycles(30);
      total++; if (n_reads !== base) $display("[TB] FAIL to_no_retry: got %0d required %0d", n_reads, base); else passed++;
      total++; if (tmo !== 1'b1)     $display("[TB] FAIL to_sticky: got %b required 1", tmo); else passed++;
      enable = 1'b0;
      cycles(3);
      total++; if (tmo !== 1'b0)     $display("[TB] FAIL to_clear: got %b required 0", tmo); else passed++;
      total++; if (level !== 3'd0)   $display("[TB] FAIL to_fifo_empty: got %0d required 0", level); else passed++;
      ack_en = 1'b1;
      ack_delay = 1;
      exp_addr = 8'd3;
      exp_q.delete();
      enable = 1'b1;
      wait_cyc_high("to_restart");
      total++; if (adr !== 10'h00C)  $display("[TB] FAIL to_restart_adr: got %h required 00C", adr); else passed++;
      cycles(10);
      enable = 1'b0;
      cycles(12);
   endtask

   task automatic test_enable_drop();
      int n;
      ack_delay = 3;
      ready = 1'b0;
      applyStimulus(8'd4, 8'd7);
      enable = 1'b1;
      wait_cyc_high("ed");
      enable = 1'b0;
      n = 0;
      while (cyc && n < 50) begin
         cycles(1);
         n++;
      end
      total++; if (n !== 4)           $display("[TB] FAIL ed_complete: cyc_cycles=%0d required 4", n); else passed++;
      total++; if (level !== 3'd1)    $display("[TB] FAIL ed_pushed: level=%0d required 1", level); else passed++;
      total++; if (sample !== 32'hA4) $display("[TB] FAIL ed_word: got %h required A4", sample); else passed++;
      cycles(3);
      total++; if (level !== 3'd0)    $display("[TB] FAIL ed_flush: level=%0d required 0", level); else passed++;
      total++; if (adr !== 10'h010)   $display("[TB] FAIL ed_rearm: adr=%h required 010", adr); else passed++;
      total++; if (cyc !== 1'b0)      $display("[TB] FAIL ed_no_cyc: cyc=%b required 0", cyc); else passed++;
      exp_q.delete();
   endtask

   task automatic checkOutput();
      total++; if (cyc !== 1'b0)      $display("[TB] FAIL ar_cyc: %b required 0", cyc); else passed++;
      total++; if (stb !== 1'b0)      $display("[TB] FAIL ar_stb: %b required 0", stb); else passed++;
      total++; if (wb_rst_o !== 1'b1) $display("[TB] FAIL ar_rst_o: %b required 1", wb_rst_o); else passed++;
      total++; if (adr !== 10'd0)     $display("[TB] FAIL ar_adr: %h required 0", adr); else passed++;
      total++; if (level !== 3'd0)    $display("[TB] FAIL ar_level: %0d required 0", level); else passed++;
      total++; if (valid !== 1'b0)    $display("[TB] FAIL ar_valid: %b required 0", valid); else passed++;
      total++; if (sample !== 32'd0)  $display("[TB] FAIL ar_sample: %h required 0", sample); else passed++;
      total++; if (wrap !== 1'b0)     $display("[TB] FAIL ar_wrap: %b required 0", wrap); else passed++;
      total++; if (tmo !== 1'b0)      $display("[TB] FAIL ar_timeout: %b required 0", tmo); else passed++;
   endtask

   task automatic test_async_reset();
      ack_delay = 5;
      ready = 1'b0;
      applyStimulus(8'd6, 8'd7);
      enable = 1'b1;
      wait_cyc_high("ar");
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput();
      enable = 1'b0;
      cycles(3);
      @(negedge clk);
      rst_n = 1'b1;
      exp_q.delete();
      cycles(2);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) ram[i] = 32'h1000 + i;
      for (int i = 0; i < 8; i++) ram[i] = 32'hA0 + i;
      exp_addr = 8'd0;
      test_reset();
      test_sequential();
      test_backpressure();
      test_inverted();
      test_timeout();
      test_enable_drop();
      test_async_reset();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
